// File: rtl/tea_pkg.sv
// tea_pkg: constants and types shared by the TEA decryption engine.
//   state_t            - control FSM encoding (IDLE/LOADING/PROCESSING/DONE)
//   DELTA              - TEA key-schedule constant
//   NUM_ROUNDS_DEFAULT - default number of TEA cycles
//   sum_init()         - starting sum for decryption, DELTA*n modulo 2^32
//   SUM_INIT           - sum_init() at the default round count
package tea_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    LOADING    = 2'b01,
    PROCESSING = 2'b10,
    DONE       = 2'b11
  } state_t;

  localparam logic [31:0] DELTA              = 32'h9E37_79B9;
  localparam int          NUM_ROUNDS_DEFAULT = 32;

  function automatic logic [31:0] sum_init(input int n);
    return DELTA * 32'(n);
  endfunction

  localparam logic [31:0] SUM_INIT = sum_init(NUM_ROUNDS_DEFAULT);

endpackage

// File: rtl/tea_dec_round.sv
// tea_dec_round: one combinational TEA decryption cycle.
//   v0, v1   in  32   current half-blocks
//   sum      in  32   current schedule sum
//   key      in  128  k0=[127:96], k1=[95:64], k2=[63:32], k3=[31:0]
//   v0_nxt   out 32   updated v0 (uses the already-updated v1)
//   v1_nxt   out 32   updated v1
//   sum_nxt  out 32   sum - DELTA
module tea_dec_round
  import tea_pkg::*;
(
  input  logic [31:0]  v0,
  input  logic [31:0]  v1,
  input  logic [31:0]  sum,
  input  logic [127:0] key,
  output logic [31:0]  v0_nxt,
  output logic [31:0]  v1_nxt,
  output logic [31:0]  sum_nxt
);

  logic [31:0] k0, k1, k2, k3;

  assign k0 = key[127:96];
  assign k1 = key[95:64];
  assign k2 = key[63:32];
  assign k3 = key[31:0];

  // Exact inverse of the encryptor cycle: undo v1 first, then v0 from new v1.
  assign v1_nxt  = v1 - (((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
  assign v0_nxt  = v0 - (((v1_nxt << 4) + k0) ^ (v1_nxt + sum) ^ ((v1_nxt >> 5) + k1));
  assign sum_nxt = sum - DELTA;

endmodule

// File: rtl/tea_decryptor.sv
// tea_decryptor: TEA block decryption with AXI-Stream in/out, fixed latency.
//   i_clk           in   1    clock
//   i_rst_n         in   1    async active-low reset
//   i_key           in   128  key, captured on input handshake
//   i_axis_valid_s  in   1    ciphertext valid
//   o_axis_ready_s  out  1    ready for ciphertext (IDLE only)
//   i_axis_data_s   in   64   ciphertext {v0, v1}
//   o_axis_valid_m  out  1    plaintext valid
//   i_axis_ready_m  in   1    downstream ready
//   o_axis_data_m   out  64   plaintext {v0, v1}
//
// state      | meaning
// IDLE       | waiting for a ciphertext block, ready_s high
// LOADING    | block and key captured, sum/counter initialised
// PROCESSING | one decryption cycle per clock, NUM_ROUNDS clocks
// DONE       | plaintext presented until the master handshake
module tea_decryptor
  import tea_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [127:0] i_key,
  input  logic         i_axis_valid_s,
  output logic         o_axis_ready_s,
  input  logic [63:0]  i_axis_data_s,
  output logic         o_axis_valid_m,
  input  logic         i_axis_ready_m,
  output logic [63:0]  o_axis_data_m
);

  localparam int          CNT_W     = $clog2(NUM_ROUNDS) + 1;
  localparam logic [31:0] SUM_START = sum_init(NUM_ROUNDS);

  state_t             state, next_state;
  logic [31:0]        v0, v1, sum;
  logic [127:0]       key;
  logic [CNT_W-1:0]   round_counter;
  logic [31:0]        v0_nxt, v1_nxt, sum_nxt;
  logic               last_round;

  tea_dec_round u_round (
    .v0      (v0),
    .v1      (v1),
    .sum     (sum),
    .key     (key),
    .v0_nxt  (v0_nxt),
    .v1_nxt  (v1_nxt),
    .sum_nxt (sum_nxt)
  );

  assign o_axis_ready_s = (state == IDLE);
  assign last_round     = (round_counter == CNT_W'(NUM_ROUNDS - 1));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (i_axis_valid_s) next_state = LOADING;
      LOADING:    next_state = PROCESSING;
      PROCESSING: if (last_round) next_state = DONE;
      DONE:       if (i_axis_ready_m) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      v0             <= '0;
      v1             <= '0;
      sum            <= '0;
      key            <= '0;
      round_counter  <= '0;
      o_axis_valid_m <= 1'b0;
      o_axis_data_m  <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (i_axis_valid_s) begin
            v0  <= i_axis_data_s[63:32];
            v1  <= i_axis_data_s[31:0];
            key <= i_key;
          end
        end
        LOADING: begin
          sum           <= SUM_START;
          round_counter <= '0;
        end
        PROCESSING: begin
          v0            <= v0_nxt;
          v1            <= v1_nxt;
          sum           <= sum_nxt;
          round_counter <= round_counter + CNT_W'(1);
          // Output register loads with the final cycle's result so DONE
          // presents it without an extra stage.
          if (last_round) begin
            o_axis_valid_m <= 1'b1;
            o_axis_data_m  <= {v0_nxt, v1_nxt};
          end
        end
        DONE: begin
          if (i_axis_ready_m) o_axis_valid_m <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_decryptor.sv
// tb_tea_decryptor: scoreboard bench for tea_decryptor.
// Inputs are driven 1 time unit after posedge; outputs are sampled on negedge.
module tb_tea_decryptor;

  localparam logic [31:0] TB_DELTA = 32'h9E37_79B9;
  localparam int          LATENCY  = 34;  // handshake cycle -> first valid cycle

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b1;
  logic [127:0] i_key = '0;
  logic         i_axis_valid_s = 1'b0;
  logic         o_axis_ready_s;
  logic [63:0]  i_axis_data_s = '0;
  logic         o_axis_valid_m;
  logic         i_axis_ready_m = 1'b1;
  logic [63:0]  o_axis_data_m;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit rand_rdy = 1'b0;

  logic [63:0] exp_q[$];
  int          hs_q[$];

  tea_decryptor dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_key          (i_key),
    .i_axis_valid_s (i_axis_valid_s),
    .o_axis_ready_s (o_axis_ready_s),
    .i_axis_data_s  (i_axis_data_s),
    .o_axis_valid_m (o_axis_valid_m),
    .i_axis_ready_m (i_axis_ready_m),
    .o_axis_data_m  (o_axis_data_m)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  // Reference TEA written straight from the algorithm definition.
  function automatic logic [63:0] m_enc(input logic [63:0] p, input logic [127:0] k);
    logic [31:0] a, b, s;
    a = p[63:32]; b = p[31:0]; s = 0;
    for (int i = 0; i < 32; i++) begin
      s = s + TB_DELTA;
      a = a + (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
      b = b + (((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]));
    end
    return {a, b};
  endfunction

  function automatic logic [63:0] m_dec(input logic [63:0] c, input logic [127:0] k);
    logic [31:0] a, b, s;
    a = c[63:32]; b = c[31:0]; s = 0;
    for (int i = 0; i < 32; i++) s = s + TB_DELTA;
    for (int i = 0; i < 32; i++) begin
      b = b - (((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]));
      a = a - (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
      s = s - TB_DELTA;
    end
    return {a, b};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic send(input logic [63:0] d, input logic [127:0] k, input logic [63:0] e);
    bit done;
    done = 1'b0;
    i_axis_valid_s = 1'b1;
    i_axis_data_s  = d;
    i_key          = k;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge i_clk);
      if (o_axis_ready_s) begin
        exp_q.push_back(e);
        hs_q.push_back(cyc);
        done = 1'b1;
      end
      @(posedge i_clk); #1;
      if (rand_rdy) i_axis_ready_m = 1'($urandom_range(0, 1));
    end
    // Disturb data and key after acceptance; the block in flight must not care.
    i_axis_valid_s = 1'b0;
    i_axis_data_s  = {$urandom, $urandom};
    i_key          = rnd128();
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(posedge i_clk); #1;
      if (rand_rdy) i_axis_ready_m = 1'($urandom_range(0, 1));
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    i_axis_ready_m = 1'b1;
  endtask

  initial begin
    logic [63:0]  p, c, pa, pb, ca, cb;
    logic [127:0] k, ka, kb;
    int           busy;
    bit           seen;

    fork
      begin : monitor
        bit prev_valid;
        prev_valid = 1'b0;
        forever begin
          @(negedge i_clk);
          if (!i_rst_n) prev_valid = 1'b0;
          else begin
            if (o_axis_valid_m && !prev_valid) begin
              if (hs_q.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
              else check("latency", 64'(cyc - hs_q[0]), 64'(LATENCY));
            end
            if (o_axis_valid_m && i_axis_ready_m) begin
              if (exp_q.size() == 0) check("extra_output", o_axis_data_m, 64'hx);
              else begin
                check("plaintext", o_axis_data_m, exp_q.pop_front());
                void'(hs_q.pop_front());
              end
            end
            prev_valid = o_axis_valid_m;
          end
        end
      end
    join_none

    // Reset state
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_ready_s", 64'(o_axis_ready_s), 64'd1);
    check("rst_valid_m", 64'(o_axis_valid_m), 64'd0);
    check("rst_data_m",  o_axis_data_m, 64'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // Known vector: zero key, zero plaintext
    send(64'h41EA3A0A_94BAA940, 128'd0, 64'd0);
    drain();

    // Round trip through the reference encryptor
    k = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    send(m_enc(64'h01234567_89ABCDEF, k), k, 64'h01234567_89ABCDEF);
    drain();

    // Constant time: extremes of data and key (latency checked per block)
    send(64'd0, 128'd0, m_dec(64'd0, 128'd0));
    drain();
    send({64{1'b1}}, {128{1'b1}}, m_dec({64{1'b1}}, {128{1'b1}}));
    drain();

    // Backpressure in DONE for 10 cycles
    i_axis_ready_m = 1'b0;
    k = rnd128(); p = {$urandom, $urandom};
    send(m_enc(p, k), k, p);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge i_clk);
      seen = o_axis_valid_m;
    end
    check("bp_valid_seen", 64'(seen), 64'd1);
    for (int j = 0; j < 10; j++) begin
      check("bp_valid_hold", 64'(o_axis_valid_m), 64'd1);
      check("bp_data_hold",  o_axis_data_m, p);
      check("bp_ready_s",    64'(o_axis_ready_s), 64'd0);
      @(negedge i_clk);
    end
    @(posedge i_clk); #1 i_axis_ready_m = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    check("bp_release_ready_s", 64'(o_axis_ready_s), 64'd1);
    check("bp_release_valid_m", 64'(o_axis_valid_m), 64'd0);
    @(posedge i_clk); #1;
    drain();

    // Busy rejection: new block held valid through the whole operation
    ka = rnd128(); pa = {$urandom, $urandom}; ca = m_enc(pa, ka);
    kb = rnd128(); pb = {$urandom, $urandom}; cb = m_enc(pb, kb);
    send(ca, ka, pa);
    i_axis_valid_s = 1'b1; i_axis_data_s = cb; i_key = kb;
    busy = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge i_clk);
      if (o_axis_ready_s) begin
        exp_q.push_back(pb);
        hs_q.push_back(cyc);
        seen = 1'b1;
      end else busy++;
    end
    check("busy_cycles", 64'(busy), 64'(LATENCY));
    @(posedge i_clk); #1;
    i_axis_valid_s = 1'b0;
    i_key = rnd128();
    drain();

    // Reset while round_counter is 15
    k = rnd128(); p = {$urandom, $urandom};
    send(m_enc(p, k), k, p);
    repeat (16) @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    #1;
    check("midrst_ready_s", 64'(o_axis_ready_s), 64'd1);
    check("midrst_valid_m", 64'(o_axis_valid_m), 64'd0);
    check("midrst_data_m",  o_axis_data_m, 64'd0);
    exp_q.delete();
    hs_q.delete();
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    k = rnd128(); p = {$urandom, $urandom};
    send(m_enc(p, k), k, p);
    drain();

    // Random blocks with random downstream backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 20; n++) begin
      k = rnd128(); p = {$urandom, $urandom};
      if (n % 2 == 0) send(m_enc(p, k), k, p);
      else begin
        c = {$urandom, $urandom};
        send(c, k, m_dec(c, k));
      end
    end
    drain();
    rand_rdy = 1'b0;
    repeat (3) @(posedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
